// File: rtl/truth_sweep_pkg.sv
// Shared definitions for the truth-table sweep controller: state encoding,
// vector count and counter widths.
package truth_sweep_pkg;

    localparam int NUM_VEC = 16;
    localparam int IDX_W   = 4;
    localparam int DWELL_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } sweep_state_t;

endpackage

// File: rtl/truth_sweep_dwell_timer.sv
// dwell_timer: 8-bit cycle counter that measures how long the current input
// vector has been held. expire is high on the last hold cycle (count ==
// DWELL-1); the counter wraps back to zero on that cycle so the next vector
// starts a fresh dwell.
module dwell_timer
    import truth_sweep_pkg::*;
#(
    parameter int DWELL = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [DWELL_W-1:0] LAST = DWELL_W'(DWELL - 1);

    logic [DWELL_W-1:0] r_count;

    assign expire = (r_count == LAST);

    // Count hold cycles; clear has priority, wrap to zero on expiry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= expire ? '0 : r_count + 8'd1;
        end
    end

endmodule

// File: rtl/truth_sweep_ctrl.sv
// truth_sweep_ctrl: drives all 16 input vectors {a,b,c,d} onto a 4-input
// combinational unit, holds each for DWELL cycles, and captures the f/g
// responses into 16-bit truth tables. Optional macro SWEEP_CHECK_EN adds
// expected-table inputs, a mismatch counter and a pass flag.
//
// Control inputs: start and abort are plain levels sampled at the rising
// edge; there is no ready. start is acted on only in IDLE and only when abort
// is low; abort is acted on only in DRIVE. done is a registered one-cycle
// pulse that follows the DONE state by one edge.
module truth_sweep_ctrl
    import truth_sweep_pkg::*;
#(
    parameter int DWELL = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        f,
    input  logic        g,
`ifdef SWEEP_CHECK_EN
    input  logic [15:0] exp_f,
    input  logic [15:0] exp_g,
    output logic [5:0]  mism_cnt,
    output logic        pass,
`endif
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic [15:0] tt_f,
    output logic [15:0] tt_g,
    output logic [1:0]  o_dbg_state
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);

    sweep_state_t     r_state;
    sweep_state_t     w_next;
    logic [IDX_W-1:0] r_idx;
    logic             r_done;
    logic [15:0]      r_tt_f;
    logic [15:0]      r_tt_g;
    logic             w_expire;
    logic             w_start_ok;
    logic             w_sample;
    logic             w_in_drive;
    logic [IDX_W-1:0] w_abcd;

    assign w_in_drive = (r_state == DRIVE);
    assign w_start_ok = (r_state == IDLE) && start && !abort;
    // abort beats a coinciding sample: the vector in flight is not captured.
    assign w_sample   = w_in_drive && !abort && w_expire;
    assign w_abcd     = w_in_drive ? r_idx : '0;

    assign {a, b, c, d} = w_abcd;
    assign busy         = w_in_drive;
    assign done         = r_done;
    assign tt_f         = r_tt_f;
    assign tt_g         = r_tt_g;
    assign o_dbg_state  = r_state;

    dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (!w_in_drive || abort),
        .en     (w_in_drive),
        .expire (w_expire)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start_ok) w_next = DRIVE;
            DRIVE: begin
                if (abort) begin
                    w_next = IDLE;
                end else if (w_sample && (r_idx == LAST_IDX)) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Vector index, completion pulse and truth-table capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_done <= 1'b0;
            r_tt_f <= '0;
            r_tt_g <= '0;
        end else begin
            r_done <= (r_state == DONE);
            if (w_start_ok) begin
                r_idx <= '0;
            end else if (w_sample && (r_idx != LAST_IDX)) begin
                r_idx <= r_idx + 4'd1;
            end
            if (w_sample) begin
                r_tt_f[r_idx] <= f;
                r_tt_g[r_idx] <= g;
            end
        end
    end

`ifdef SWEEP_CHECK_EN
    logic [5:0] r_mism;

    assign mism_cnt = r_mism;
    assign pass     = (r_mism == 6'd0);

    // Accumulate response mismatches against the expected tables.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mism <= '0;
        end else if (w_start_ok) begin
            r_mism <= '0;
        end else if (w_sample) begin
            r_mism <= r_mism + {5'd0, (f != exp_f[r_idx])}
                             + {5'd0, (g != exp_g[r_idx])};
        end
    end
`endif

endmodule

// File: tb/tb_truth_sweep_ctrl.sv
// Bench for truth_sweep_ctrl: two instances (DWELL=2 on a parity/AND unit,
// DWELL=1 on an inverter/zero unit) checked every cycle against a model that
// tracks time since the accepted start. Honours SWEEP_CHECK_EN.
`timescale 1ns/1ps
module tb_truth_sweep_ctrl;

    localparam int DW0 = 2;
    localparam int DW1 = 1;
    localparam logic [15:0] EXP_F0 = 16'h6996;
    localparam logic [15:0] EXP_G0 = 16'h8008;  // bit 3 deliberately wrong
    localparam logic [15:0] EXP_F1 = 16'h5555;
    localparam logic [15:0] EXP_G1 = 16'h0000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start0, abort0, start1, abort1, inv0, chk_on;
    logic a0, b0, c0, d0, f0, g0, busy0, done0;
    logic a1, b1, c1, d1, f1, g1, busy1, done1;
    logic [15:0] ttf0, ttg0, ttf1, ttg1;
    logic [1:0] st0, st1;
    logic [5:0] mism0, mism1;
    logic pass0, pass1;
    int n_checks = 0;
    int n_errors = 0;

    // Units under sequence; inv0 lets a sweep capture a different table.
    assign f0 = (a0 ^ b0 ^ c0 ^ d0) ^ inv0;
    assign g0 = a0 & b0 & c0 & d0;
    assign f1 = ~d1;
    assign g1 = 1'b0;

    truth_sweep_ctrl #(.DWELL(DW0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .f(f0), .g(g0),
`ifdef SWEEP_CHECK_EN
        .exp_f(EXP_F0), .exp_g(EXP_G0), .mism_cnt(mism0), .pass(pass0),
`endif
        .a(a0), .b(b0), .c(c0), .d(d0), .busy(busy0), .done(done0),
        .tt_f(ttf0), .tt_g(ttg0), .o_dbg_state(st0)
    );

    truth_sweep_ctrl #(.DWELL(DW1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .f(f1), .g(g1),
`ifdef SWEEP_CHECK_EN
        .exp_f(EXP_F1), .exp_g(EXP_G1), .mism_cnt(mism1), .pass(pass1),
`endif
        .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1),
        .tt_f(ttf1), .tt_g(ttg1), .o_dbg_state(st1)
    );

`ifndef SWEEP_CHECK_EN
    assign mism0 = 6'd0;
    assign mism1 = 6'd0;
    assign pass0 = 1'b1;
    assign pass1 = 1'b1;
`endif

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_t = cycles since the accepted start: 1..16*DW busy with vector
    // (m_t-1)/DW, sampled when m_t is a multiple of DW; 16*DW+1 is the
    // completion cycle; done shows one edge later.
    int          dw[2] = '{DW0, DW1};
    int          m_t[2];
    int          m_mism[2];
    logic [15:0] m_ttf[2];
    logic [15:0] m_ttg[2];
    logic        m_done[2];
    logic [15:0] m_expf[2] = '{EXP_F0, EXP_F1};
    logic [15:0] m_expg[2] = '{EXP_G0, EXP_G1};
    logic        m_s, m_ab, m_uf, m_ug;
    logic [3:0]  m_v;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            m_s  = (k == 0) ? start0 : start1;
            m_ab = (k == 0) ? abort0 : abort1;
            if (!rst_n) begin
                m_t[k] = 0; m_mism[k] = 0; m_ttf[k] = '0; m_ttg[k] = '0; m_done[k] = 1'b0;
            end else begin
                m_done[k] = (m_t[k] == 16 * dw[k] + 1);
                if (m_t[k] == 0) begin
                    if (m_s && !m_ab) begin
                        m_t[k] = 1;
                        m_mism[k] = 0;
                    end
                end else if (m_t[k] <= 16 * dw[k]) begin
                    if (m_ab) begin
                        m_t[k] = 0;
                    end else begin
                        if (m_t[k] % dw[k] == 0) begin
                            m_v  = 4'(m_t[k] / dw[k] - 1);
                            m_uf = (k == 0) ? ((^m_v) ^ inv0) : ~m_v[0];
                            m_ug = (k == 0) ? (m_v == 4'd15) : 1'b0;
                            m_ttf[k][m_v] = m_uf;
                            m_ttg[k][m_v] = m_ug;
                            m_mism[k] = m_mism[k] + int'(m_uf != m_expf[k][m_v])
                                                  + int'(m_ug != m_expg[k][m_v]);
                        end
                        m_t[k]++;
                    end
                end else begin
                    m_t[k] = 0;
                end
            end
        end
    end

    // Compare every cycle on the falling edge.
    logic       c_busy;
    logic [3:0] c_abcd;
    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 2; k++) begin
                c_busy = (m_t[k] >= 1) && (m_t[k] <= 16 * dw[k]);
                c_abcd = c_busy ? 4'((m_t[k] - 1) / dw[k]) : 4'd0;
                check($sformatf("busy%0d", k), 16'(k == 0 ? busy0 : busy1), 16'(c_busy));
                check($sformatf("done%0d", k), 16'(k == 0 ? done0 : done1), 16'(m_done[k]));
                check($sformatf("abcd%0d", k),
                      16'(k == 0 ? {a0, b0, c0, d0} : {a1, b1, c1, d1}), 16'(c_abcd));
                check($sformatf("tt_f%0d", k), k == 0 ? ttf0 : ttf1, m_ttf[k]);
                check($sformatf("tt_g%0d", k), k == 0 ? ttg0 : ttg1, m_ttg[k]);
`ifdef SWEEP_CHECK_EN
                check($sformatf("mism%0d", k), 16'(k == 0 ? mism0 : mism1), 16'(m_mism[k]));
                if (m_done[k])
                    check($sformatf("pass%0d", k), 16'(k == 0 ? pass0 : pass1),
                          16'(m_mism[k] == 0));
`endif
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Starts the selected instances at edge 0, then runs len cycles; inputs
    // named by an edge number are driven during the cycle before that edge.
    task automatic run(input logic s0, input logic s1, input int inj_start, input int ab_at,
                       input int rst_at, input int len,
                       output int at0, output int n0, output int at1, output int n1);
        at0 = -1; at1 = -1; n0 = 0; n1 = 0;
        @(negedge clk);
        start0 = s0; start1 = s1;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        for (int cnt = 1; cnt <= len; cnt++) begin
            start0 = (cnt == inj_start);
            abort0 = (cnt == ab_at);
            rst_n  = !(cnt == rst_at);
            @(negedge clk);
            if (done0) begin if (at0 < 0) at0 = cnt; n0++; end
            if (done1) begin if (at1 < 0) at1 = cnt; n1++; end
        end
        start0 = 1'b0; abort0 = 1'b0; rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    int at0, n0, at1, n1;
    initial begin
        rst_n = 1'b0; start0 = 1'b0; abort0 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
        inv0 = 1'b0; chk_on = 1'b0;
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        check("rst_busy0", 16'(busy0), 16'd0);
        check("rst_abcd0", 16'({a0, b0, c0, d0}), 16'd0);
        check("rst_ttf0", ttf0, 16'h0000);
        check("rst_done1", 16'(done1), 16'd0);
        rst_n = 1'b1;

        // Full sweeps on both instances.
        run(1'b1, 1'b1, -1, -1, -1, 40, at0, n0, at1, n1);
        check("lat_dw2", 16'(at0), 16'd33);
        check("lat_dw1", 16'(at1), 16'd17);
        check("ndone_dw2", 16'(n0), 16'd1);
        check("ndone_dw1", 16'(n1), 16'd1);
        check("ttf_parity", ttf0, 16'h6996);
        check("ttg_and", ttg0, 16'h8000);
        check("ttf_notd", ttf1, 16'h5555);
        check("ttg_zero", ttg1, 16'h0000);

        // Second start during a sweep is ignored.
        run(1'b1, 1'b0, 5, -1, -1, 40, at0, n0, at1, n1);
        check("restart_lat", 16'(at0), 16'd33);
        check("restart_ndone", 16'(n0), 16'd1);

        // Abort one cycle after vector 4 is sampled, inverted unit.
        inv0 = 1'b1;
        run(1'b1, 1'b0, -1, 11, -1, 40, at0, n0, at1, n1);
        inv0 = 1'b0;
        check("abort_ndone", 16'(n0), 16'd0);
        check("abort_ttf", ttf0, 16'h6989);
        check("abort_ttg", ttg0, 16'h8000);

        // start and abort together in IDLE: stay idle.
        @(negedge clk); start0 = 1'b1; abort0 = 1'b1;
        @(negedge clk); start0 = 1'b0; abort0 = 1'b0;
        check("start_abort_idle", 16'(busy0), 16'd0);
        repeat (3) @(negedge clk);

        // Reset mid-sweep, then a fresh sweep on both.
        run(1'b1, 1'b0, -1, -1, 10, 40, at0, n0, at1, n1);
        check("rst_mid_ndone", 16'(n0), 16'd0);
        check("rst_mid_ttf0", ttf0, 16'h0000);
        check("rst_mid_ttf1", ttf1, 16'h0000);
        run(1'b1, 1'b1, -1, -1, -1, 40, at0, n0, at1, n1);
        check("post_rst_lat", 16'(at0), 16'd33);
        check("post_rst_ttf0", ttf0, 16'h6996);
        check("post_rst_ttf1", ttf1, 16'h5555);
`ifdef SWEEP_CHECK_EN
        check("mism_cnt0", 16'(mism0), 16'd1);
        check("pass0", 16'(pass0), 16'd0);
        check("mism_cnt1", 16'(mism1), 16'd0);
        check("pass1", 16'(pass1), 16'd1);
`endif

        // ---------------- report ----------------
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/truth_sweep_ctrl.md
TRUTH_SWEEP_CTRL -- requirements
Module: truth_sweep_ctrl

Interface
REQ-001 SHALL have parameter DWELL, default 2, clock cycles each input vector is held before sampling; legal range 1..255.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  input  1  single-cycle request to begin a 16-vector sweep.
REQ-005 SHALL have port abort  input  1  terminates a sweep in progress.
REQ-006 SHALL have port a, b, c, d  output  1 each  stimulus to the 4-input combinational unit under sequence; a is MSB.
REQ-007 SHALL have port f, g  input  1 each  responses of the combinational unit.
REQ-008 SHALL have port busy  output  1  high while a sweep runs.
REQ-009 SHALL have port done  output  1  one-cycle pulse on sweep completion.
REQ-010 SHALL have port tt_f, tt_g  output  16 each  captured truth tables; bit i holds the response to vector {a,b,c,d}=i.

Function
REQ-011 SHALL implement FSM states IDLE, DRIVE, DONE.
REQ-012 IDLE: {a,b,c,d}=4'b0000, busy=0; start=1 -> DRIVE with vector index 0 and dwell count 0.
REQ-013 DRIVE: {a,b,c,d}=index, busy=1; the dwell counter increments each cycle.
REQ-014 DRIVE, dwell count = DWELL-1: tt_f[index]<=f and tt_g[index]<=g; dwell resets; index<15 -> index+1, else -> DONE.
REQ-015 DONE: done=1 for exactly one cycle, busy=0, {a,b,c,d}=0000; unconditionally -> IDLE.
REQ-016 start-to-done latency SHALL be 16*DWELL+1 cycles (start sampled at edge 0; done high after edge 16*DWELL+1).
REQ-017 start while busy or in DONE SHALL be ignored.
REQ-018 abort in DRIVE SHALL force IDLE at the next edge with no done pulse; already captured bits are retained and uncaptured bits keep prior values.
REQ-019 abort and start together in IDLE: abort SHALL win and the FSM stays in IDLE.
REQ-020 The index SHALL be 4 bits with no wrap past 15; the dwell counter SHALL be 8 bits.
REQ-021 tt_f/tt_g SHALL hold their values between sweeps until overwritten.

Reset
REQ-022 rst_n=0 at an edge SHALL force IDLE, index=0, dwell=0, a=b=c=d=0, busy=0, done=0, tt_f=tt_g=16'h0000, including mid-sweep.
REQ-023 No output SHALL change asynchronously to clk.

Configuration
REQ-024 With SWEEP_CHECK_EN defined: add inputs exp_f and exp_g (16 bits each), and outputs mism_cnt (6 bits) and pass (1 bit); at each sample, mism_cnt increments by (f!=exp_f[index])+(g!=exp_g[index]); mism_cnt clears on accepted start and on reset; pass=(mism_cnt==0) and is valid in the done cycle and thereafter.
REQ-025 Without SWEEP_CHECK_EN: these ports and the checking logic SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-026 Package truth_sweep_pkg SHALL hold the state encoding (IDLE=2'd0, DRIVE=2'd1, DONE=2'd2), NUM_VEC=16 and IDX_W=4.
REQ-027 Sub-module dwell_timer SHALL hold the 8-bit dwell counter, with inputs clr/en and output expire (count==DWELL-1).

Verification
REQ-028 DWELL=2, f=a^b^c^d, g=a&b&c&d, one start pulse -> done at cycle 33; tt_f=16'h6996; tt_g=16'h8000.
REQ-029 DWELL=1, f=~d, g=0 -> done at cycle 17; tt_f=16'h5555; tt_g=16'h0000; {a,b,c,d} steps 0..15 one per cycle.
REQ-030 Second start pulse at cycle 5 of a sweep -> ignored; done occurs once at 16*DWELL+1.
REQ-031 abort in the cycle after vector 4 is sampled -> IDLE next edge, no done, tt_f[4:0] updated and tt_f[15:5] unchanged.
REQ-032 rst_n low at cycle 10 mid-sweep -> next edge all outputs 0 and FSM in IDLE; a new start then completes normally.
REQ-033 SWEEP_CHECK_EN, exp_f=16'h6996 with the parity unit, exp_g wrong only in bit 3 -> mism_cnt=1, pass=0 at done.
